// File: rtl/game_pkg.sv
// game_pkg: shared round_scorer state encoding and timing defaults.
package game_pkg;
  localparam int ROM_LAT_DEF    = 2;
  localparam int REPORT_GAP_DEF = 16;
  localparam int CNT_W          = 8;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_GUESS, CHECK, REPORT, GAP} state_e;
endpackage

// File: rtl/cycle_delay.sv
// cycle_delay: loadable down-counter; done_o is high while the count sits at zero.
module cycle_delay #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         done_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  assign done_o = cnt_q == '0;
endmodule

// File: rtl/round_scorer.sv
// round_scorer: walks a pattern RAM against player presses and reports the round score
// with a single enable pulse, then holds off new rounds for REPORT_GAP cycles.
module round_scorer import game_pkg::*; #(
  parameter int ROM_LAT    = ROM_LAT_DEF,
  parameter int REPORT_GAP = REPORT_GAP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] playerID,
  input  logic       start,
  input  logic [3:0] round_len,
  input  logic       guess_valid,
  input  logic [3:0] guess,
  input  logic [3:0] expected,
  output logic [3:0] seq_idx,
  output logic [3:0] newScore,
  output logic       enable,
  output logic [3:0] playerID_out,
  output logic       busy,
  output logic       round_ok
);
  state_e state_q, state_d;
  logic [3:0] pid_q, pid_d, len_q, len_d, idx_q, idx_d, score_q, score_d;
  logic [3:0] exp_q, exp_d, guess_q, guess_d, new_score_q, new_score_d, pid_out_q, pid_out_d;
  logic enable_q, enable_d, busy_q, busy_d, ok_q, ok_d;
  logic ld, dec, done;
  logic [CNT_W-1:0] ld_val;

  cycle_delay #(.W(CNT_W)) u_delay (
    .clk(clk), .rst_n(rst), .load_i(ld), .load_val_i(ld_val), .dec_i(dec), .done_o(done)
  );

  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    len_d   = len_q;
    idx_d   = idx_q;
    score_d = score_q;
    exp_d   = exp_q;
    guess_d = guess_q;
    busy_d  = busy_q;
    ok_d    = ok_q;
    ld      = 1'b0;
    ld_val  = '0;
    dec     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        pid_d   = playerID;
        len_d   = round_len;
        idx_d   = '0;
        score_d = '0;
        busy_d  = 1'b1;
        ok_d    = round_len == 4'd0;
        state_d = round_len == 4'd0 ? REPORT : FETCH;
        ld      = 1'b1;
        ld_val  = CNT_W'(ROM_LAT - 1);
      end
      FETCH: if (done) begin
        exp_d   = expected;
        state_d = WAIT_GUESS;
      end else dec = 1'b1;
      WAIT_GUESS: if (guess_valid) begin
        guess_d = guess;
        state_d = CHECK;
      end
      CHECK: if (guess_q == exp_q) begin
        score_d = score_q + 4'd1;
        if ({1'b0, idx_q} + 5'd1 < {1'b0, len_q}) begin
          idx_d   = idx_q + 4'd1;
          state_d = FETCH;
          ld      = 1'b1;
          ld_val  = CNT_W'(ROM_LAT - 1);
        end else begin
          ok_d    = 1'b1;
          state_d = REPORT;
        end
      end else begin
        ok_d    = 1'b0;
        state_d = REPORT;
      end
      REPORT: begin
        state_d = GAP;
        ld      = 1'b1;
        ld_val  = CNT_W'(REPORT_GAP - 1);
      end
      GAP: if (done) begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end else dec = 1'b1;
      default: state_d = IDLE;
    endcase
    // Result registers load on entry to REPORT so they rise together with enable.
    enable_d    = state_d == REPORT;
    new_score_d = enable_d ? score_d : new_score_q;
    pid_out_d   = enable_d ? pid_d : pid_out_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pid_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      score_q     <= '0;
      exp_q       <= '0;
      guess_q     <= '0;
      new_score_q <= '0;
      pid_out_q   <= '0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
      ok_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pid_q       <= pid_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      score_q     <= score_d;
      exp_q       <= exp_d;
      guess_q     <= guess_d;
      new_score_q <= new_score_d;
      pid_out_q   <= pid_out_d;
      enable_q    <= enable_d;
      busy_q      <= busy_d;
      ok_q        <= ok_d;
    end
  end

  assign seq_idx      = idx_q;
  assign newScore     = new_score_q;
  assign enable       = enable_q;
  assign playerID_out = pid_out_q;
  assign busy         = busy_q;
  assign round_ok     = ok_q;
endmodule

// File: tb/tb_round_scorer.sv
// tb_round_scorer: randomized rounds against a pattern-RAM model and a score reference model.
module tb_round_scorer;
  localparam int R = 2;
  localparam int G = 16;

  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] playerID = '0, round_len = '0, guess = '0, expected;
  logic start = 1'b0, guess_valid = 1'b0;
  logic [3:0] seq_idx, newScore, playerID_out;
  logic enable, busy, round_ok;

  logic [3:0] pat [16];
  logic [3:0] gs [16];
  logic [3:0] ram_q = '0;
  int tests = 0, fails = 0, pulses = 0;

  round_scorer #(.ROM_LAT(R), .REPORT_GAP(G)) dut (
    .clk(clk), .rst(rst), .playerID(playerID), .start(start), .round_len(round_len),
    .guess_valid(guess_valid), .guess(guess), .expected(expected), .seq_idx(seq_idx),
    .newScore(newScore), .enable(enable), .playerID_out(playerID_out), .busy(busy),
    .round_ok(round_ok)
  );

  always #5 clk = ~clk;

  // Pattern RAM: data for an address becomes sampleable R edges after the address changes.
  always @(posedge clk) ram_q <= pat[seq_idx];
  assign expected = ram_q;

  always @(posedge clk) if (enable) pulses++;

  task automatic play_round(input logic [3:0] pid, input logic [3:0] len, input bit inject);
    int score, nused, p0, nw;
    bit ok, bad;
    score = 0;
    ok = 1'b1;
    for (int i = 0; i < int'(len); i++) begin
      if (gs[i] !== pat[i]) begin ok = 1'b0; break; end
      score++;
    end
    nused = ok ? int'(len) : score + 1;
    p0 = pulses;
    @(negedge clk);
    playerID = pid; round_len = len; start = 1'b1; guess_valid = inject; guess = 4'hF;
    @(negedge clk);
    start = 1'b0; guess_valid = 1'b0; playerID = 4'($urandom); round_len = 4'($urandom);
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_after_start got=%b want=1", busy); end
    for (int i = 0; i < nused; i++) begin
      nw = (i == 0 ? R : R + 1) + int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++) begin
        start = inject; playerID = 4'($urandom); round_len = 4'($urandom);
        guess_valid = inject && (w == (i == 0 ? 0 : 1));
        guess = gs[i] ^ 4'hF;
        @(negedge clk);
      end
      start = 1'b0; guess_valid = 1'b1; guess = gs[i];
      @(negedge clk);
      guess_valid = 1'b0; guess = 4'($urandom);
    end
    if (len != 4'd0 || enable !== 1'b1) @(negedge clk);
    tests++;
    if (enable !== 1'b1 || newScore !== 4'(score) || round_ok !== ok || playerID_out !== pid) begin
      fails++;
      $display("FAIL report en=%b score=%0d ok=%b pid=%h want en=1 score=%0d ok=%b pid=%h",
               enable, newScore, round_ok, playerID_out, score, ok, pid);
    end
    @(negedge clk);
    tests++;
    if (enable !== 1'b0 || pulses != p0 + 1) begin
      fails++; $display("FAIL single_pulse en=%b pulses=%0d want en=0 pulses=%0d", enable, pulses - p0, 1);
    end
    bad = 1'b0;
    for (int k = 1; k <= G; k++) begin
      if (busy !== 1'b1) bad = 1'b1;
      start = inject && k == 1;
      @(negedge clk);
      start = 1'b0;
    end
    tests++;
    if (bad || busy !== 1'b0) begin
      fails++; $display("FAIL busy_gap early_drop=%b busy_end=%b want 0/0", bad, busy);
    end
    tests++;
    if (newScore !== 4'(score) || playerID_out !== pid || pulses != p0 + 1) begin
      fails++;
      $display("FAIL hold score=%0d pid=%h pulses=%0d want %0d %h 1", newScore, playerID_out, pulses - p0, score, pid);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    tests++;
    if ({seq_idx, newScore, enable, playerID_out, busy, round_ok} !== 15'd0) begin
      fails++; $display("FAIL reset_outputs got=%h want=0", {seq_idx, newScore, enable, playerID_out, busy, round_ok});
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b0 || enable !== 1'b0) begin
      fails++; $display("FAIL reset_holds busy=%b en=%b want 0 0", busy, enable);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    pat[0] = 4'd5; pat[1] = 4'd2; pat[2] = 4'd9;
    gs[0] = 4'd5; gs[1] = 4'd2; gs[2] = 4'd9;
    play_round(4'hA, 4'd3, 1'b0);
    for (int i = 0; i < 4; i++) pat[i] = 4'd1;
    gs[0] = 4'd1; gs[1] = 4'd7;
    play_round(4'h3, 4'd4, 1'b0);
    play_round(4'hC, 4'd0, 1'b0);
  endtask

  task automatic test_ignore;
    for (int i = 0; i < 16; i++) begin pat[i] = 4'($urandom); gs[i] = pat[i]; end
    play_round(4'h7, 4'd4, 1'b1);
  endtask

  task automatic test_mid_reset;
    int p0;
    for (int i = 0; i < 16; i++) begin pat[i] = 4'($urandom); gs[i] = pat[i]; end
    p0 = pulses;
    @(negedge clk);
    playerID = 4'h6; round_len = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      repeat (i == 0 ? R : R + 1) @(negedge clk);
      guess_valid = 1'b1; guess = gs[i];
      @(negedge clk);
      guess_valid = 1'b0;
    end
    repeat (R + 1) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({seq_idx, newScore, enable, playerID_out, busy, round_ok} !== 15'd0) begin
      fails++; $display("FAIL async_reset got=%h want=0", {seq_idx, newScore, enable, playerID_out, busy, round_ok});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (pulses != p0) begin fails++; $display("FAIL reset_no_pulse pulses=%0d want=0", pulses - p0); end
    for (int i = 0; i < 16; i++) begin pat[i] = 4'($urandom); gs[i] = pat[i]; end
    play_round(4'h9, 4'd3, 1'b0);
  endtask

  task automatic test_full15;
    for (int i = 0; i < 16; i++) begin pat[i] = 4'($urandom); gs[i] = pat[i]; end
    play_round(4'hE, 4'd15, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 16; i++) begin
        pat[i] = 4'($urandom);
        gs[i] = ($urandom_range(0, 9) < 8) ? pat[i] : pat[i] ^ 4'($urandom_range(1, 15));
      end
      play_round(4'($urandom), 4'($urandom_range(0, 15)), n[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin pat[i] = '0; gs[i] = '0; end
    test_reset;
    test_directed;
    test_ignore;
    test_mid_reset;
    test_full15;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
